// File: rtl/sqrt_ahsqr_iter.sv
// Iterative restoring radix-2 square root with an approximate (AHSQR) mode.
// Mode 0 runs the recurrence on the top K bits only, then fills in the low root bits from the shifted radicand.
module sqrt_ahsqr_iter #(
    parameter int W = 16,
    parameter int K = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic           in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W/2-1:0] out_data,
    output logic           out_exact,
    output logic           busy
);
    localparam int H  = W / 2;
    localparam int Q  = K / 2;
    localparam int L  = H - Q;
    localparam int RW = H + 2;
    localparam int CW = $clog2(H + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    rad_cap;
    logic [W-1:0]    rad_sh;
    logic [RW-1:0]   rem;
    logic [H-1:0]    root;
    logic [CW-1:0]   cnt;
    logic            mode_cap;

    logic [RW+1:0]   rem_sh;
    logic [RW+1:0]   trial;
    logic [RW+1:0]   rem_diff;
    logic            take;

    // Low root bits: the radicand (with y halved) shifted so the leading one of q lands just above them.
    function automatic logic [H-1:0] approx_result(input logic [W-1:0] r, input logic [Q-1:0] q);
        logic [W-1:0] num;
        logic [W-1:0] sh;
        int           p;
        if (q == '0)
            return {{Q{1'b0}}, {L{1'b1}}};
        num = {r[W-1:W-K], 1'b0, r[W-K-1:1]};
        p = 0;
        for (int i = 0; i < Q; i++)
            if (q[i]) p = i;
        sh = num >> (L + p);
        return {q, sh[L-1:0]};
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        rem_sh   = {rem, rad_sh[W-1:W-2]};
        trial    = {2'b00, root, 2'b01};
        take     = (rem_sh >= trial);
        rem_diff = take ? (rem_sh - trial) : rem_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ITER;
            ITER:    if (cnt == CW'(1)) state_nxt = FIN;
            FIN:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_cap   <= '0;
            rad_sh    <= '0;
            rem       <= '0;
            root      <= '0;
            cnt       <= '0;
            mode_cap  <= 1'b0;
            out_data  <= '0;
            out_exact <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rad_cap  <= in_data;
                        rad_sh   <= in_data;
                        mode_cap <= in_mode;
                        rem      <= '0;
                        root     <= '0;
                        cnt      <= in_mode ? CW'(H) : CW'(Q);
                    end
                end
                // one root bit per cycle, two radicand bits consumed MSB-first
                ITER: begin
                    rad_sh <= {rad_sh[W-3:0], 2'b00};
                    rem    <= rem_diff[RW-1:0];
                    root   <= {root[H-2:0], take};
                    cnt    <= cnt - CW'(1);
                end
                FIN: begin
                    out_data  <= mode_cap ? root : approx_result(rad_cap, root[Q-1:0]);
                    out_exact <= mode_cap;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_ahsqr_iter.sv
// Bench for sqrt_ahsqr_iter: directed corner cases, backpressure, mid-flight reset and random traffic
// checked against an arithmetic reference of floor sqrt and the approximate fill rule.
module tb_sqrt_ahsqr_iter;
    localparam int W = 16;
    localparam int K = 6;
    localparam int H = W / 2;
    localparam int Q = K / 2;
    localparam int L = H - Q;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           in_mode = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [H-1:0]   out_data;
    logic           out_exact;
    logic           busy;

    int total = 0;
    int bad   = 0;

    sqrt_ahsqr_iter #(.W(W), .K(K)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exact(out_exact),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer floor sqrt by search, then the approximate low-bit rule.
    function automatic logic [H-1:0] model(input logic [W-1:0] r, input bit mode);
        longint z, q, num, p, m, y;
        z = mode ? longint'(r) : longint'(r >> (W - K));
        q = 0;
        while ((q + 1) * (q + 1) <= z) q++;
        if (mode) return H'(q);
        if (q == 0) return H'((1 << L) - 1);
        y   = longint'(r) & ((longint'(1) << (W - K)) - 1);
        num = z * (longint'(1) << (W - K)) + y / 2;
        p = 0;
        for (int i = 0; i < Q; i++)
            if (((q >> i) & 1) != 0) p = i;
        m = L + p;
        return H'((q << L) | ((num >> m) & ((1 << L) - 1)));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [W-1:0] r, input bit mode, input int pre_gap, input int bp);
        bit           seen;
        int           n;
        logic [H-1:0] held;
        logic         held_x;
        logic [H-1:0] exp_d;
        exp_d = model(r, mode);
        repeat (pre_gap) cyc();
        in_data  = r;
        in_mode  = mode;
        in_valid = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            seen = in_ready;
            cyc();
            n++;
        end
        chk("accept", {31'd0, seen}, 32'd1);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_mode  = 1'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            cyc();
            n++;
        end
        chk("latency", n, mode ? H + 1 : Q + 1);
        chk("out_data", {24'd0, out_data}, {24'd0, exp_d});
        chk("out_exact", {31'd0, out_exact}, {31'd0, mode});
        held   = out_data;
        held_x = out_exact;
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            in_mode  = 1'($urandom);
            cyc();
            chk("bp_data", {24'd0, out_data}, {24'd0, held});
            chk("bp_exact", {31'd0, out_exact}, {31'd0, held_x});
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("post_valid", {31'd0, out_valid}, 32'd0);
        chk("post_ready", {31'd0, in_ready}, 32'd1);
        chk("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] r;
        int           sel;
        // reset state
        repeat (2) cyc();
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_exact", {31'd0, out_exact}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // directed corner cases
        do_txn(16'hFFFF, 1'b0, 0, 0);
        chk("m0_ffff", {24'd0, model(16'hFFFF, 1'b0)}, 32'h0000_00FB);
        do_txn(16'h4000, 1'b0, 0, 1);
        do_txn(16'h0100, 1'b0, 1, 0);
        do_txn(16'hFFFF, 1'b1, 0, 0);
        do_txn(16'h0100, 1'b1, 0, 0);
        do_txn(16'h0000, 1'b1, 0, 0);
        do_txn(16'h0000, 1'b0, 0, 0);

        // long backpressure with in_valid noise
        do_txn(16'hC3A5, 1'b1, 0, 20);

        // reset at the second ITER cycle
        in_data  = 16'hFFFF;
        in_mode  = 1'b1;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", {24'd0, out_data}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rel_ready", {31'd0, in_ready}, 32'd1);
        repeat (12) begin
            cyc();
            chk("rel_valid", {31'd0, out_valid}, 32'd0);
        end
        do_txn(16'h4000, 1'b0, 0, 0);

        // random traffic
        for (int t = 0; t < 1500; t++) begin
            sel = $urandom_range(0, 7);
            r   = W'($urandom);
            if (sel == 0) r = W'($urandom_range(0, 1023));
            if (sel == 1) r = 16'hFFFF - W'($urandom_range(0, 255));
            do_txn(r, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
